// File: rtl/ram32x20_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port 32x20 RAM.
// Zero-fills the RAM after reset, then grants one access per cycle and returns read data two cycles later.
module ram32x20_arbiter #(
  parameter int DATA_W         = 20,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [ADDR_W-1:0] CLR_LAST    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CLR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   clr_r;
  logic                pri_r;
  logic                gnt0_s;
  logic                gnt1_s;
  logic                tag1_valid_r;
  logic                tag1_id_r;
  logic                rvalid0_r;
  logic                rvalid1_r;
  logic [ADDR_W-1:0]   ram_address_r;
  logic [DATA_W-1:0]   ram_data_r;
  logic                ram_wren_r;

  // Grant selection and next-state decode; pri_r breaks ties only when both request.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_r == CLR_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN: begin
        state_nxt_s = RUN;
        if (req0 && (!req1 || !pri_r)) begin
          gnt0_s = 1'b1;
        end else if (req1) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = CLEAR;
      end
    endcase
  end

  // FSM state, clear counter and round-robin priority.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= RESET_STATE;
      clr_r   <= {ADDR_W{1'b0}};
      pri_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == CLEAR && clr_r != CLR_LAST) begin
        clr_r <= clr_r + CLR_ONE;
      end
      if (gnt0_s) begin
        pri_r <= 1'b1;
      end else if (gnt1_s) begin
        pri_r <= 1'b0;
      end
    end
  end

  // RAM command register: zero-fill writes during CLEAR, winner's access in RUN.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_address_r <= {ADDR_W{1'b0}};
      ram_data_r    <= {DATA_W{1'b0}};
      ram_wren_r    <= 1'b0;
    end else if (state_r == CLEAR) begin
      ram_address_r <= clr_r;
      ram_data_r    <= {DATA_W{1'b0}};
      ram_wren_r    <= 1'b1;
    end else if (gnt0_s) begin
      ram_address_r <= addr0;
      ram_data_r    <= wdata0;
      ram_wren_r    <= we0;
    end else if (gnt1_s) begin
      ram_address_r <= addr1;
      ram_data_r    <= wdata1;
      ram_wren_r    <= we1;
    end else begin
      ram_wren_r    <= 1'b0;
    end
  end

  // Read tag pipeline; the second stage is kept one-hot so it drives rvalid directly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag1_valid_r <= 1'b0;
      tag1_id_r    <= 1'b0;
      rvalid0_r    <= 1'b0;
      rvalid1_r    <= 1'b0;
    end else begin
      tag1_valid_r <= (gnt0_s && !we0) || (gnt1_s && !we1);
      tag1_id_r    <= gnt1_s;
      rvalid0_r    <= tag1_valid_r && !tag1_id_r;
      rvalid1_r    <= tag1_valid_r && tag1_id_r;
    end
  end

  assign gnt0        = gnt0_s;
  assign gnt1        = gnt1_s;
  assign rvalid0     = rvalid0_r;
  assign rvalid1     = rvalid1_r;
  assign rdata       = ram_q;
  assign busy        = (state_r == CLEAR);
  assign ram_address = ram_address_r;
  assign ram_data    = ram_data_r;
  assign ram_wren    = ram_wren_r;

endmodule

// File: tb/tb_ram32x20_arbiter.sv
// Directed bench for ram32x20_arbiter with a behavioural 32x20 synchronous RAM attached.
module tb_ram32x20_arbiter;

  logic        clock;
  logic        resetn;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [19:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
  logic [19:0] rdata, ram_data, ram_q;
  logic [4:0]  ram_address;
  logic [19:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  ram32x20_arbiter dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: samples address on the rising edge, q valid in the following cycle.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 20'hFFFFF;
    ram_q = 20'h00000;
  end
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Walks the 32 clear cycles plus the first RUN cycle; starts right after resetn rises.
  task automatic clear_check(input logic hold_req1);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clock);
      check($sformatf("busy_clr%0d", k), busy, (k < 32));
      if (k > 0) begin
        check($sformatf("addr_clr%0d", k), ram_address, k - 1);
        check($sformatf("wren_clr%0d", k), ram_wren, 1'b1);
        check($sformatf("data_clr%0d", k), ram_data, 20'h00000);
      end
      if (hold_req1) check($sformatf("gnt1_clr%0d", k), gnt1, (k == 32));
      next_cycle();
    end
    req1 = 1'b0;
  endtask

  task automatic issue(input int side, input logic we, input logic [4:0] addr, input logic [19:0] data);
    if (side == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
    end
    @(negedge clock);
    check($sformatf("gnt0_issue_s%0d_a%0d", side, addr), gnt0, (side == 0));
    check($sformatf("gnt1_issue_s%0d_a%0d", side, addr), gnt1, (side == 1));
    next_cycle();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Called at the start of T+1 for a read granted in T.
  task automatic read_check(input int side, input logic [19:0] exp);
    @(negedge clock);
    check("rvalid0_early", rvalid0, 1'b0);
    check("rvalid1_early", rvalid1, 1'b0);
    next_cycle();
    @(negedge clock);
    check($sformatf("rvalid0_s%0d", side), rvalid0, (side == 0));
    check($sformatf("rvalid1_s%0d", side), rvalid1, (side == 1));
    check($sformatf("rdata_s%0d", side), rdata, exp);
    next_cycle();
  endtask

  initial begin
    resetn = 1'b0;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 5'd0; addr1 = 5'd0; wdata0 = 20'h00000; wdata1 = 20'h00000;
    repeat (3) next_cycle();

    @(negedge clock);
    check("rst_busy", busy, 1'b1);
    check("rst_addr", ram_address, 5'd0);
    check("rst_data", ram_data, 20'h00000);
    check("rst_wren", ram_wren, 1'b0);
    check("rst_rvalid0", rvalid0, 1'b0);
    check("rst_rvalid1", rvalid1, 1'b0);
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    next_cycle();
    resetn = 1'b1;
    req0 = 1'b0;
    clear_check(1'b0);

    // Cleared word reads back as zero.
    issue(0, 1'b0, 5'd17, 20'h00000);
    read_check(0, 20'h00000);

    // Single write then read by requester 0.
    issue(0, 1'b1, 5'd5, 20'hABCDE);
    issue(0, 1'b0, 5'd5, 20'h00000);
    read_check(0, 20'hABCDE);

    // Seed addresses 1 and 2; the requester-1 grant leaves priority with requester 0.
    issue(0, 1'b1, 5'd1, 20'h11111);
    issue(1, 1'b1, 5'd2, 20'h22222);

    // Contention: both hold read requests for four cycles.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c < 4) begin
        check($sformatf("cont_gnt0_c%0d", c), gnt0, (c % 2 == 0));
        check($sformatf("cont_gnt1_c%0d", c), gnt1, (c % 2 == 1));
      end
      if (c >= 2) begin
        check($sformatf("cont_rvalid0_c%0d", c), rvalid0, (c % 2 == 0));
        check($sformatf("cont_rvalid1_c%0d", c), rvalid1, (c % 2 == 1));
        check($sformatf("cont_rdata_c%0d", c), rdata, (c % 2 == 0) ? 20'h11111 : 20'h22222);
      end
      next_cycle();
      if (c == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end

    // Write by requester 1 immediately followed by a read of the same word by requester 0.
    issue(1, 1'b1, 5'd31, 20'h12345);
    issue(0, 1'b0, 5'd31, 20'h00000);
    read_check(0, 20'h12345);

    // Reset in the cycle after a read grant drops the pending response.
    issue(0, 1'b0, 5'd17, 20'h00000);
    resetn = 1'b0;
    @(negedge clock);
    check("midrst_busy", busy, 1'b1);
    check("midrst_addr", ram_address, 5'd0);
    check("midrst_wren", ram_wren, 1'b0);
    check("midrst_rvalid0_t1", rvalid0, 1'b0);
    next_cycle();
    @(negedge clock);
    check("midrst_rvalid0_t2", rvalid0, 1'b0);
    next_cycle();

    // Requester 1 holds a read from reset release; granted only in the first RUN cycle.
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd7;
    resetn = 1'b1;
    clear_check(1'b1);
    read_check(1, 20'h00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
